// File: rtl/pe_ctx_pkg.sv
// ---------------------------------------------------------------------------
// pe_ctx_pkg
// Shared definitions for the PE context sequencer: default widths, the
// sequencer state encoding and the idle configuration word.
// ---------------------------------------------------------------------------
package pe_ctx_pkg;

  // Default widths of the context word and the context address.
  localparam int unsigned CTX_CONF_WIDTH = 8;
  localparam int unsigned CTX_ADDR_WIDTH = 4;

  // Configuration word presented to the PE whenever it is not running.
  localparam int unsigned CONF_NOP = 0;

  // Sequencer states. DRAIN is the cycle in which the final word of the
  // final pass is on the PE bus.
  typedef logic [1:0] ctx_state_t;
  localparam ctx_state_t ST_IDLE  = 2'd0;
  localparam ctx_state_t ST_LOAD  = 2'd1;
  localparam ctx_state_t ST_RUN   = 2'd2;
  localparam ctx_state_t ST_DRAIN = 2'd3;

endpackage

// File: rtl/pe_ctx_mem.sv
// ---------------------------------------------------------------------------
// pe_ctx_mem
// DEPTH x CONF_WIDTH context memory: one synchronous write port and one
// registered read port. The read register is the PE configuration output,
// so it also has a synchronous clear back to the NOP word.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous reset, active-low (clears the read register only)
//   we     - write strobe
//   waddr  - write address
//   wdata  - write data
//   re     - read enable; the read register holds while low
//   clr    - load the NOP word into the read register
//   raddr  - read address
//   rdata  - registered read data
// ---------------------------------------------------------------------------
module pe_ctx_mem
  import pe_ctx_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = CTX_ADDR_WIDTH,
  parameter int unsigned CONF_WIDTH = CTX_CONF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [CONF_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic                  clr,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [CONF_WIDTH-1:0] rdata
);

  logic [CONF_WIDTH-1:0] mem [DEPTH];

  // Storage array: never reset, contents survive a sequencer reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      rdata <= CONF_WIDTH'(CONF_NOP);
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pe_ctx_seq.sv
// ---------------------------------------------------------------------------
// pe_ctx_seq
// Context sequencer for one CGRA processing element. Steps through a
// context memory one word per cycle, loops the program a latched number of
// passes and redirects the program counter on the PE branch flag.
//
// pc always names the word currently on pe_conf; the next word is read
// from the memory with the freshly computed next pc, so a branch costs no
// bubble.
//
// Optional feature macro: PE_CTX_SEQ_STALL_EN adds a 'stall' input that
// freezes LOAD/RUN/DRAIN (pe_en low, pe_conf held, pe_branch ignored).
//
// Ports:
//   clk, rst              - clock, synchronous active-low reset
//   cfg_we/addr/data      - context memory write port (accepted in IDLE only)
//   last_addr             - final program address, latched on start
//   iterations            - number of program passes, latched on start
//   branch_tgt            - branch target, latched on start
//   start                 - run request pulse
//   stall                 - (PE_CTX_SEQ_STALL_EN only) execution hold
//   pe_branch             - branch flag from the PE
//   pe_conf, pe_en        - registered configuration word and enable to PE
//   pe_rst                - one-cycle PE reset pulse at run start
//   busy                  - high in LOAD/RUN/DRAIN
//   done                  - one-cycle pulse when a run completes
// ---------------------------------------------------------------------------
module pe_ctx_seq
  import pe_ctx_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = CTX_ADDR_WIDTH,
  parameter int unsigned CONF_WIDTH = CTX_CONF_WIDTH,
  parameter int unsigned ITER_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [CONF_WIDTH-1:0] cfg_data,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  input  logic [ITER_WIDTH-1:0] iterations,
  input  logic [ADDR_WIDTH-1:0] branch_tgt,
  input  logic                  start,
`ifdef PE_CTX_SEQ_STALL_EN
  input  logic                  stall,
`endif
  input  logic                  pe_branch,
  output logic [CONF_WIDTH-1:0] pe_conf,
  output logic                  pe_en,
  output logic                  pe_rst,
  output logic                  busy,
  output logic                  done
);

  // One extra bit so pass arithmetic never overflows at the maximum count.
  localparam int unsigned CNT_WIDTH = ITER_WIDTH + 1;

  ctx_state_t            state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt;
  logic [ITER_WIDTH-1:0] iter_cnt, iter_nxt;
  logic [ADDR_WIDTH-1:0] last_q, tgt_q;
  logic [ITER_WIDTH-1:0] iters_q;
  logic [ADDR_WIDTH-1:0] rd_addr_c;
  logic                  rd_en_c, rd_clr_c, latch_c, wr_en_c;
  logic                  en_nxt, rst_pulse_nxt, done_nxt;
  logic                  stall_c, hold_c, more_c, ending_c;

`ifdef PE_CTX_SEQ_STALL_EN
  assign stall_c = stall;
`else
  assign stall_c = 1'b0;
`endif

  // Stall only freezes an active run; IDLE keeps reacting to start.
  assign hold_c  = stall_c && (state != ST_IDLE);
  // True while at least one more full pass follows the current one.
  assign more_c  = (CNT_WIDTH'(iter_cnt) + CNT_WIDTH'(1)) < CNT_WIDTH'(iters_q);
  assign wr_en_c = cfg_we && (state == ST_IDLE);

  // Next-state, next-pc and registered-output decode.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    iter_nxt      = iter_cnt;
    latch_c       = 1'b0;
    rd_en_c       = 1'b0;
    rd_clr_c      = 1'b0;
    rd_addr_c     = pc;
    en_nxt        = 1'b0;
    rst_pulse_nxt = 1'b0;
    done_nxt      = 1'b0;
    ending_c      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          if (iterations == '0) begin
            done_nxt = 1'b1;
          end else begin
            latch_c       = 1'b1;
            pc_nxt        = '0;
            iter_nxt      = '0;
            rst_pulse_nxt = 1'b1;
            state_nxt     = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        // pc is already 0: fetch it so it lands on pe_conf next cycle.
        if (!hold_c) begin
          rd_en_c   = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      default: begin
        // RUN and DRAIN share the next-pc priority; DRAIN only ends when
        // no branch is taken.
        if (!hold_c) begin
          if (pe_branch) begin
            pc_nxt = tgt_q;
          end else if (pc == last_q) begin
            if (more_c) begin
              pc_nxt   = '0;
              iter_nxt = iter_cnt + ITER_WIDTH'(1);
            end else begin
              ending_c = 1'b1;
            end
          end else begin
            pc_nxt = pc + ADDR_WIDTH'(1);
          end

          if (ending_c) begin
            state_nxt = ST_IDLE;
            rd_clr_c  = 1'b1;
            done_nxt  = 1'b1;
          end else begin
            rd_en_c   = 1'b1;
            state_nxt = ST_RUN;
          end
        end
      end
    endcase

    // Any fetched word is issued next cycle; flag it as DRAIN when it is
    // the last word of the last pass.
    if (rd_en_c) begin
      rd_addr_c = pc_nxt;
      en_nxt    = 1'b1;
      if ((pc_nxt == last_q) &&
          ((CNT_WIDTH'(iter_nxt) + CNT_WIDTH'(1)) >= CNT_WIDTH'(iters_q))) begin
        state_nxt = ST_DRAIN;
      end
    end
  end

  // State, program counter and latched run parameters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      pc       <= '0;
      iter_cnt <= '0;
      last_q   <= '0;
      iters_q  <= '0;
      tgt_q    <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      iter_cnt <= iter_nxt;
      if (latch_c) begin
        last_q  <= last_addr;
        iters_q <= iterations;
        tgt_q   <= branch_tgt;
      end
    end
  end

  // Registered control outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pe_en  <= 1'b0;
      pe_rst <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      pe_en  <= en_nxt;
      pe_rst <= rst_pulse_nxt;
      busy   <= (state_nxt != ST_IDLE);
      done   <= done_nxt;
    end
  end

  // Context memory; its read register drives pe_conf directly.
  pe_ctx_mem #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CONF_WIDTH (CONF_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en_c),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .re    (rd_en_c),
    .clr   (rd_clr_c),
    .raddr (rd_addr_c),
    .rdata (pe_conf)
  );

endmodule

// File: tb/tb_pe_ctx_seq.sv
// ---------------------------------------------------------------------------
// tb_pe_ctx_seq
// Bench for pe_ctx_seq. The expected word stream of every run is derived
// from the program rules (address list per pass, branches, passes) before
// the run starts; a per-cycle compare process checks all outputs against
// the expectation set for that cycle.
// ---------------------------------------------------------------------------
module tb_pe_ctx_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_data;
  logic [3:0] last_addr;
  logic [15:0] iterations;
  logic [3:0] branch_tgt;
  logic       start;
  logic       stall;
  logic       pe_branch;
  logic [7:0] pe_conf;
  logic       pe_en, pe_rst, busy, done;

`ifdef PE_CTX_SEQ_STALL_EN
  localparam bit HAS_STALL = 1'b1;
`else
  localparam bit HAS_STALL = 1'b0;
`endif

  pe_ctx_seq dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .last_addr  (last_addr),
    .iterations (iterations),
    .branch_tgt (branch_tgt),
    .start      (start),
`ifdef PE_CTX_SEQ_STALL_EN
    .stall      (stall),
`endif
    .pe_branch  (pe_branch),
    .pe_conf    (pe_conf),
    .pe_en      (pe_en),
    .pe_rst     (pe_rst),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int en_seen  = 0;
  int done_seen = 0;
  bit chk_on   = 1'b0;

  logic [7:0] exp_conf;
  logic       exp_en, exp_rst, exp_busy, exp_done;

  logic [7:0] ctx_m [16];
  logic [3:0] tr_addr [$];
  bit         tr_br   [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, expv, $time);
    end
  endtask

  // Per-cycle compare against the expectation for the current cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("pe_conf", 32'(pe_conf), 32'(exp_conf));
      chk("pe_en",   32'(pe_en),   32'(exp_en));
      chk("pe_rst",  32'(pe_rst),  32'(exp_rst));
      chk("busy",    32'(busy),    32'(exp_busy));
      chk("done",    32'(done),    32'(exp_done));
    end
  end

  always @(negedge clk) begin
    if (pe_en === 1'b1) en_seen++;
    if (done === 1'b1) done_seen++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end at t=%0t", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    exp_conf = 8'h00; exp_en = 1'b0; exp_rst = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
  endtask

  task automatic write_ctx(input logic [3:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    step();
    ctx_m[a] = d;
    set_idle();
    cfg_we = 1'b0;
  endtask

  // Address sequence the program must issue, from the sequencing rules.
  // br_mode: 0 no branches, 1 branch at word index br_k, 2 random (max 3).
  task automatic gen_trace(input logic [3:0] la, input int it, input logic [3:0] tg,
                           input int br_mode, input int br_k);
    logic [3:0] pc;
    int pass, nbr, k;
    bit b, stop;
    tr_addr.delete(); tr_br.delete();
    pc = 4'd0; pass = 0; nbr = 0; k = 0; stop = 1'b0;
    while (!stop) begin
      tr_addr.push_back(pc);
      if (br_mode == 1) b = (k == br_k);
      else if (br_mode == 2) b = (nbr < 3) && ($urandom_range(0, 5) == 0);
      else b = 1'b0;
      tr_br.push_back(b);
      k++;
      if (b) begin
        pc = tg; nbr++;
      end else if (pc == la) begin
        if (pass + 1 < it) begin pc = 4'd0; pass++; end
        else stop = 1'b1;
      end else begin
        pc = pc + 4'd1;
      end
    end
  endtask

  // One complete run from an idle cycle back to an idle cycle.
  task automatic run_prog(input logic [3:0] la, input int it, input logic [3:0] tg,
                          input int br_mode, input int br_k, input int st_at,
                          input int st_len, input bit wr_mid, output int len);
    int k, cyc;
    bit s, prev_s;
    gen_trace(la, it, tg, br_mode, br_k);
    len = tr_addr.size();
    last_addr = la; iterations = 16'(it); branch_tgt = tg; start = 1'b1;
    step();
    // LOAD cycle
    exp_conf = 8'h00; exp_en = 1'b0; exp_rst = 1'b1; exp_busy = 1'b1; exp_done = 1'b0;
    start = 1'($urandom); last_addr = 4'($urandom); iterations = 16'($urandom_range(0, 3));
    branch_tgt = 4'($urandom); pe_branch = 1'($urandom);
    k = 0; cyc = 0; prev_s = 1'b0;
    while (k < len) begin
      step();
      exp_conf = ctx_m[tr_addr[k]]; exp_en = !prev_s; exp_rst = 1'b0;
      exp_busy = 1'b1; exp_done = 1'b0;
      s = HAS_STALL && (cyc >= st_at) && (cyc < st_at + st_len);
      stall = s;
      pe_branch = s ? 1'($urandom) : tr_br[k];
      start = 1'($urandom); last_addr = 4'($urandom);
      iterations = 16'($urandom_range(0, 3)); branch_tgt = 4'($urandom);
      cfg_we = wr_mid && (cyc == 1); cfg_addr = 4'd0; cfg_data = 8'hFF;
      if (!s) k++;
      prev_s = s;
      cyc++;
    end
    step();
    set_idle();
    exp_done = 1'b1;
    start = 1'b0; pe_branch = 1'b0; stall = 1'b0; cfg_we = 1'b0;
    step();
    set_idle();
  endtask

  initial begin
    int len, en0, dn0;
    rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; last_addr = '0;
    iterations = '0; branch_tgt = '0; start = 1'b0; stall = 1'b0; pe_branch = 1'b0;
    set_idle();
    step();
    chk_on = 1'b1;
    step();
    rst = 1'b1;
    step();

    for (int i = 0; i < 16; i++) write_ctx(4'(i), 8'($urandom));
    write_ctx(4'd0, 8'h11); write_ctx(4'd1, 8'h22);
    write_ctx(4'd2, 8'h33); write_ctx(4'd3, 8'h44);

    // Single pass of four words.
    en0 = en_seen; dn0 = done_seen;
    run_prog(4'd3, 1, 4'd0, 0, 0, 0, 0, 1'b0, len);
    chk("t1_len", 32'(len), 32'd4);
    chk("t1_en_cycles", 32'(en_seen - en0), 32'd4);
    chk("t1_done_pulses", 32'(done_seen - dn0), 32'd1);

    // Three passes.
    en0 = en_seen; dn0 = done_seen;
    run_prog(4'd3, 3, 4'd0, 0, 0, 0, 0, 1'b0, len);
    chk("t2_len", 32'(len), 32'd12);
    chk("t2_en_cycles", 32'(en_seen - en0), 32'd12);
    chk("t2_done_pulses", 32'(done_seen - dn0), 32'd1);

    // Branch to 1 while word 2 is executing.
    run_prog(4'd3, 1, 4'd1, 1, 2, 0, 0, 1'b0, len);
    chk("t3_len", 32'(len), 32'd6);
    chk("t3_a3", 32'(tr_addr[3]), 32'd1);
    chk("t3_a4", 32'(tr_addr[4]), 32'd2);
    chk("t3_a5", 32'(tr_addr[5]), 32'd3);

    // Zero iterations: immediate done, no run.
    last_addr = 4'd3; iterations = 16'd0; start = 1'b1;
    step();
    set_idle(); exp_done = 1'b1;
    start = 1'b0;
    step();
    set_idle();
    step();

    // Write attempt during a run is ignored; the rerun still sees 8'h11.
    run_prog(4'd3, 2, 4'd0, 0, 0, 0, 0, 1'b1, len);
    run_prog(4'd3, 1, 4'd0, 0, 0, 0, 0, 1'b0, len);
    chk("t5_ctx0_model", 32'(ctx_m[0]), 32'h11);

    // Reset mid-run: outputs clear next cycle, no done pulse.
    dn0 = done_seen;
    last_addr = 4'd3; iterations = 16'd2; branch_tgt = 4'd0; start = 1'b1;
    step();
    exp_conf = 8'h00; exp_en = 1'b0; exp_rst = 1'b1; exp_busy = 1'b1; exp_done = 1'b0;
    start = 1'b0; pe_branch = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_conf = ctx_m[i]; exp_en = 1'b1; exp_rst = 1'b0; exp_busy = 1'b1; exp_done = 1'b0;
    end
    rst = 1'b0;
    step();
    set_idle();
    rst = 1'b1;
    repeat (4) step();
    chk("t6_no_done", 32'(done_seen - dn0), 32'd0);
    en0 = en_seen;
    run_prog(4'd3, 1, 4'd0, 0, 0, 0, 0, 1'b0, len);
    chk("t6_rerun_en", 32'(en_seen - en0), 32'd4);

    // Stall for three cycles in the middle (only when the feature exists).
    en0 = en_seen;
    run_prog(4'd3, 1, 4'd0, 0, 0, 1, 3, 1'b0, len);
    chk("t7_en_cycles", 32'(en_seen - en0), 32'd4);

    // One-word program.
    en0 = en_seen;
    run_prog(4'd0, 2, 4'd0, 0, 0, 0, 0, 1'b0, len);
    chk("t8_en_cycles", 32'(en_seen - en0), 32'd2);

    // Randomized programs, branches, noise and stalls.
    for (int r = 0; r < 25; r++) begin
      if (r % 5 == 0) begin
        for (int i = 0; i < 16; i++) write_ctx(4'(i), 8'($urandom));
      end
      run_prog(4'($urandom), $urandom_range(1, 3), 4'($urandom), 2, 0,
               $urandom_range(0, 6), $urandom_range(0, 3), 1'($urandom), len);
    end

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
